scan_poll_fifo: RTL and testbench

- Parametrised multi-channel polling controller that steps an analogue mux address across CH_NUM channels and waits a programmable settle time per channel.
- Samples the AD converter output and pushes each sample into an internal FIFO.
- Appends a two-byte line terminator after every completed scan.
- Successor to the fixed 32-channel poller: adds runtime settle delay and cycle count, continuous mode, graceful stop, overflow flag, fill level and a done pulse. Sits between the AD front end and the UART/host drain logic.

---
 rtl/scan_poll_pkg.sv | 30 +++
 rtl/sync_fifo_fwft_n.sv | 61 ++++++
 rtl/scan_poll_fifo.sv | 157 +++++++++++++++
 tb/tb_scan_poll_fifo.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/scan_poll_pkg.sv
// Shared types and constants for the channel-scanning poller and its FIFO.
package scan_poll_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      SETTLE = 3'd1,
      SAMPLE = 3'd2,
      WRITE  = 3'd3,
      TERM_A = 3'd4,
      TERM_B = 3'd5,
      CHECK  = 3'd6
   } state_t;

   localparam logic [7:0] DEF_TERM0 = 8'h0D;
   localparam logic [7:0] DEF_TERM1 = 8'h0A;

   // Number of bits needed to encode values 0..value-1.
   function automatic int clog2(input int value);
      int result;
      int rem;
      result = 0;
      rem    = value - 1;
      while (rem > 0) begin
         result = result + 1;
         rem    = rem >> 1;
      end
      return result;
   endfunction

endpackage

// File: rtl/sync_fifo_fwft_n.sv
// Synchronous FIFO with registered read data, fill count and drop indication.
module sync_fifo_fwft_n #(
   parameter int DATA_W  = 8,
   parameter int FIFO_AW = 6
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               wrreq,
   input  logic [DATA_W-1:0]  data,
   input  logic               rdreq,
   output logic [DATA_W-1:0]  q,
   output logic               empty,
   output logic               full,
   output logic [FIFO_AW:0]   usedw,
   output logic               wr_drop
);

   localparam int DEPTH = 2 ** FIFO_AW;

   logic [DATA_W-1:0]  mem [DEPTH];
   logic [FIFO_AW-1:0] wr_ptr;
   logic [FIFO_AW-1:0] rd_ptr;
   logic               wr_ok;
   logic               rd_ok;

   assign full    = (usedw == (FIFO_AW + 1)'(DEPTH));
   assign empty   = (usedw == '0);
   assign rd_ok   = rdreq && !empty;
   // A read in the same cycle frees the slot a full FIFO would otherwise refuse.
   assign wr_ok   = wrreq && (!full || rdreq);
   assign wr_drop = wrreq && !wr_ok;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         usedw  <= '0;
         q      <= '0;
      end else begin
         if (wr_ok) begin
            wr_ptr <= wr_ptr + FIFO_AW'(1);
         end
         if (rd_ok) begin
            rd_ptr <= rd_ptr + FIFO_AW'(1);
            q      <= mem[rd_ptr];
         end
         case ({wr_ok, rd_ok})
            2'b10:   usedw <= usedw + (FIFO_AW + 1)'(1);
            2'b01:   usedw <= usedw - (FIFO_AW + 1)'(1);
            default: usedw <= usedw;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (wr_ok) begin
         mem[wr_ptr] <= data;
      end
   end

endmodule

// File: rtl/scan_poll_fifo.sv
// Multi-channel AD polling controller: steps the mux, settles, samples each
// channel into a FIFO and closes every scan with a two-word terminator.
module scan_poll_fifo
   import scan_poll_pkg::*;
#(
   parameter int          DATA_W  = 8,
   parameter int          CH_NUM  = 32,
   parameter int          ADDR_W  = clog2(CH_NUM),
   parameter int          DELAY_W = 32,
   parameter int          FIFO_AW = 6,
   parameter logic [7:0]  TERM0   = DEF_TERM0,
   parameter logic [7:0]  TERM1   = DEF_TERM1
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               start,
   input  logic               stop,
   input  logic [DELAY_W-1:0] cfg_delay,
   input  logic [7:0]         cfg_cycles,
   input  logic [DATA_W-1:0]  ad_data,
   output logic [ADDR_W-1:0]  addr,
   output logic               ad_sample,
   output logic               busy,
   output logic               done,
   input  logic               rdreq,
   output logic [DATA_W-1:0]  q,
   output logic               empty,
   output logic               full,
   output logic [FIFO_AW:0]   usedw,
   output logic               overflow
);

   state_t               state;
   state_t               state_nx;
   logic [DELAY_W-1:0]   delay_lat;
   logic [DELAY_W-1:0]   settle_cnt;
   logic [7:0]           cycles_lat;
   logic [7:0]           cycle_cnt;
   logic [7:0]           cycle_inc;
   logic                 stop_pend;
   logic [DATA_W-1:0]    sample;
   logic                 push;
   logic [DATA_W-1:0]    push_data;
   logic                 wr_drop;
   logic                 last_ch;
   logic                 settle_end;
   logic                 finish;

   assign last_ch    = (addr == ADDR_W'(CH_NUM - 1));
   assign settle_end = (settle_cnt == delay_lat - DELAY_W'(1));
   assign cycle_inc  = cycle_cnt + 8'd1;
   // A stop arriving in the CHECK cycle itself is honoured immediately.
   assign finish     = stop_pend || stop ||
                       ((cycles_lat != 8'd0) && (cycle_inc == cycles_lat));
   assign ad_sample  = (state == SAMPLE);
   assign busy       = (state != IDLE);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   always_comb begin
      state_nx  = state;
      push      = 1'b0;
      push_data = sample;
      case (state)
         IDLE:    if (start) state_nx = SETTLE;
         SETTLE:  if (settle_end) state_nx = SAMPLE;
         SAMPLE:  state_nx = WRITE;
         WRITE: begin
            push     = 1'b1;
            state_nx = last_ch ? TERM_A : SETTLE;
         end
         TERM_A: begin
            push      = 1'b1;
            push_data = DATA_W'(TERM0);
            state_nx  = TERM_B;
         end
         TERM_B: begin
            push      = 1'b1;
            push_data = DATA_W'(TERM1);
            state_nx  = CHECK;
         end
         CHECK:   state_nx = finish ? IDLE : SETTLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         delay_lat  <= '0;
         cycles_lat <= '0;
         cycle_cnt  <= '0;
         settle_cnt <= '0;
         stop_pend  <= 1'b0;
         overflow   <= 1'b0;
         addr       <= '0;
         done       <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  delay_lat  <= (cfg_delay == '0) ? DELAY_W'(1) : cfg_delay;
                  cycles_lat <= cfg_cycles;
                  cycle_cnt  <= '0;
                  stop_pend  <= 1'b0;
                  overflow   <= 1'b0;
                  addr       <= '0;
               end
            end
            // Counter returns to zero on exit so every SETTLE entry starts clean.
            SETTLE:  settle_cnt <= settle_end ? '0 : settle_cnt + DELAY_W'(1);
            WRITE:   if (!last_ch) addr <= addr + ADDR_W'(1);
            CHECK: begin
               cycle_cnt <= cycle_inc;
               addr      <= '0;
               done      <= finish;
            end
            default: ;
         endcase
         if (stop && (state != IDLE)) begin
            stop_pend <= 1'b1;
         end
         if (wr_drop) begin
            overflow <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (state == SAMPLE) begin
         sample <= ad_data;
      end
   end

   sync_fifo_fwft_n #(
      .DATA_W  (DATA_W),
      .FIFO_AW (FIFO_AW)
   ) u_fifo (
      .clk     (clk),
      .reset_n (reset_n),
      .wrreq   (push),
      .data    (push_data),
      .rdreq   (rdreq),
      .q       (q),
      .empty   (empty),
      .full    (full),
      .usedw   (usedw),
      .wr_drop (wr_drop)
   );

endmodule

// File: tb/tb_scan_poll_fifo.sv
// Directed bench for scan_poll_fifo: a vector table of scan configurations
// plus hand-written overflow, full-with-read, stop and mid-scan reset sequences.
module tb_scan_poll_fifo;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        start, start_s, stop;
   logic [31:0] cfg_delay;
   logic [7:0]  cfg_cycles;
   logic [7:0]  ad_data, ad_data_s;
   logic [1:0]  addr, addr_s;
   logic        ad_sample, ad_sample_s, busy, busy_s, done, done_s;
   logic        rdreq, rdreq_s;
   logic [7:0]  q, q_s;
   logic        empty, empty_s, full, full_s, overflow, overflow_s;
   logic [6:0]  usedw;
   logic [3:0]  usedw_s;

   int n_vec = 0;
   int n_bad = 0;

   always #10 clk = ~clk;

   assign ad_data   = 8'h10 + {6'd0, addr};
   assign ad_data_s = 8'h10 + {6'd0, addr_s};

   scan_poll_fifo #(.CH_NUM(4), .ADDR_W(2), .FIFO_AW(6)) dut (
      .clk(clk), .reset_n(reset_n), .start(start), .stop(stop),
      .cfg_delay(cfg_delay), .cfg_cycles(cfg_cycles), .ad_data(ad_data),
      .addr(addr), .ad_sample(ad_sample), .busy(busy), .done(done),
      .rdreq(rdreq), .q(q), .empty(empty), .full(full), .usedw(usedw),
      .overflow(overflow));

   scan_poll_fifo #(.CH_NUM(4), .ADDR_W(2), .FIFO_AW(3)) dut_s (
      .clk(clk), .reset_n(reset_n), .start(start_s), .stop(stop),
      .cfg_delay(cfg_delay), .cfg_cycles(cfg_cycles), .ad_data(ad_data_s),
      .addr(addr_s), .ad_sample(ad_sample_s), .busy(busy_s), .done(done_s),
      .rdreq(rdreq_s), .q(q_s), .empty(empty_s), .full(full_s), .usedw(usedw_s),
      .overflow(overflow_s));

   typedef struct {
      int delay;
      int cycles;
      int start_len;
      int restart_at;
      int exp_lat;
      int exp_words;
   } vec_t;

   vec_t vecs[5];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Stream order for CH_NUM=4 with ad_data = 0x10 + channel.
   function automatic logic [7:0] exp_word(input int k);
      int i;
      i = k % 6;
      if (i < 4) return 8'h10 + 8'(i);
      else if (i == 4) return 8'h0D;
      else return 8'h0A;
   endfunction

   task automatic drain_main(input int n, input string tag);
      rdreq = 1'b1;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         check({tag, "_q"}, {24'd0, q}, {24'd0, exp_word(i)});
      end
      @(negedge clk);
      rdreq = 1'b0;
      check({tag, "_q_hold"}, {24'd0, q}, {24'd0, exp_word(n - 1)});
      check({tag, "_empty"}, {31'd0, empty}, 32'd1);
      check({tag, "_usedw0"}, {25'd0, usedw}, 32'd0);
   endtask

   task automatic drain_small(input int n, input int off, input string tag);
      rdreq_s = 1'b1;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         check({tag, "_q"}, {24'd0, q_s}, {24'd0, exp_word(i + off)});
      end
      rdreq_s = 1'b0;
      @(negedge clk);
      check({tag, "_empty"}, {31'd0, empty_s}, 32'd1);
   endtask

   task automatic run_main(input vec_t v, input string tag);
      int n;
      int h;
      n = 0;
      h = 1;
      cfg_delay  = v.delay;
      cfg_cycles = 8'(v.cycles);
      start      = 1'b1;
      @(negedge clk);
      check({tag, "_busy"}, {31'd0, busy}, 32'd1);
      cfg_delay  = 32'd77;
      cfg_cycles = 8'd9;
      while (n < 5000) begin
         start = (h < v.start_len) || (v.restart_at != 0 && n == v.restart_at);
         h++;
         @(negedge clk);
         n++;
         if (done) break;
      end
      start = 1'b0;
      check({tag, "_latency"}, n, v.exp_lat);
      @(negedge clk);
      check({tag, "_done_once"}, {31'd0, done}, 32'd0);
      check({tag, "_idle"}, {31'd0, busy}, 32'd0);
      check({tag, "_usedw"}, {25'd0, usedw}, v.exp_words);
      check({tag, "_ovf"}, {31'd0, overflow}, 32'd0);
      drain_main(v.exp_words, tag);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int n;
      int ndone;
      reset_n = 1'b0; start = 1'b0; start_s = 1'b0; stop = 1'b0;
      rdreq = 1'b0; rdreq_s = 1'b0; cfg_delay = 32'd0; cfg_cycles = 8'd0;
      vecs[0] = '{3, 2, 1,  0, 46, 12};
      vecs[1] = '{1, 1, 1,  0, 15,  6};
      vecs[2] = '{0, 1, 5,  0, 15,  6};
      vecs[3] = '{5, 3, 1, 40, 93, 18};
      vecs[4] = '{2, 2, 2, 10, 38, 12};

      repeat (2) @(negedge clk);
      check("rst_addr", {30'd0, addr}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_done", {31'd0, done}, 32'd0);
      check("rst_sample", {31'd0, ad_sample}, 32'd0);
      check("rst_q", {24'd0, q}, 32'd0);
      check("rst_usedw", {25'd0, usedw}, 32'd0);
      check("rst_empty", {31'd0, empty}, 32'd1);
      check("rst_full", {31'd0, full}, 32'd0);
      check("rst_ovf", {31'd0, overflow}, 32'd0);
      reset_n = 1'b1;
      @(negedge clk);

      for (int i = 0; i < 5; i++) begin
         run_main(vecs[i], $sformatf("vec%0d", i));
      end

      // Overflow on the 8-word FIFO: three scans, nothing read.
      cfg_delay = 32'd3; cfg_cycles = 8'd3; start_s = 1'b1;
      @(negedge clk);
      start_s = 1'b0;
      n = 0;
      while (n < 2000 && !done_s) begin
         @(negedge clk);
         n++;
      end
      check("ovf_latency", n, 69);
      @(negedge clk);
      check("ovf_idle", {31'd0, busy_s}, 32'd0);
      check("ovf_usedw", {28'd0, usedw_s}, 32'd8);
      check("ovf_full", {31'd0, full_s}, 32'd1);
      check("ovf_flag", {31'd0, overflow_s}, 32'd1);
      drain_small(8, 0, "ovf");
      check("ovf_sticky", {31'd0, overflow_s}, 32'd1);

      // Push into a full FIFO with a read in the same cycle.
      cfg_cycles = 8'd2; start_s = 1'b1;
      @(negedge clk);
      start_s = 1'b0;
      n = 0;
      while (n < 2000 && !full_s) begin
         @(negedge clk);
         n++;
      end
      check("fr_ovf_cleared", {31'd0, overflow_s}, 32'd0);
      n = 0;
      while (n < 2000 && !ad_sample_s) begin
         @(negedge clk);
         n++;
      end
      @(negedge clk);
      rdreq_s = 1'b1;
      @(negedge clk);
      rdreq_s = 1'b0;
      check("fr_ovf", {31'd0, overflow_s}, 32'd0);
      check("fr_usedw", {28'd0, usedw_s}, 32'd8);
      check("fr_full", {31'd0, full_s}, 32'd1);
      check("fr_q", {24'd0, q_s}, 32'h10);
      n = 0;
      while (n < 2000 && !done_s) begin
         @(negedge clk);
         n++;
      end
      @(negedge clk);
      check("fr_ovf_later", {31'd0, overflow_s}, 32'd1);
      drain_small(8, 1, "fr");

      // Continuous mode, stop during channel 2 of scan 3.
      cfg_delay = 32'd1; cfg_cycles = 8'd0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      n = 0;
      while (n < 2000 && !(usedw == 7'd14 && addr == 2'd2)) begin
         @(negedge clk);
         n++;
      end
      check("stop_reached", n < 2000, 1);
      stop = 1'b1;
      @(negedge clk);
      stop = 1'b0;
      n = 0;
      ndone = 0;
      while (n < 200) begin
         @(negedge clk);
         n++;
         if (done) ndone++;
      end
      check("stop_done_count", ndone, 1);
      check("stop_idle", {31'd0, busy}, 32'd0);
      check("stop_usedw", {25'd0, usedw}, 32'd18);
      drain_main(18, "stop");

      // Asynchronous reset in the middle of a settle period.
      cfg_delay = 32'd5; cfg_cycles = 8'd1; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      n = 0;
      while (n < 2000 && addr != 2'd2) begin
         @(negedge clk);
         n++;
      end
      check("mid_usedw", {25'd0, usedw}, 32'd2);
      reset_n = 1'b0;
      #1;
      check("arst_addr", {30'd0, addr}, 32'd0);
      check("arst_busy", {31'd0, busy}, 32'd0);
      check("arst_usedw", {25'd0, usedw}, 32'd0);
      check("arst_empty", {31'd0, empty}, 32'd1);
      check("arst_q", {24'd0, q}, 32'd0);
      check("arst_ovf", {31'd0, overflow}, 32'd0);
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      run_main(vecs[1], "post_rst");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
